// File: rtl/decode_strobe_qualifier_pkg.sv
// decode_strobe_qualifier_pkg: shared FSM state encodings and default decode inversion mask
package decode_strobe_qualifier_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, HOLD = 2'd2, WAIT_REL = 2'd3} state_t;
   localparam logic [4:0] DEF_INV_MASK = 5'b00111;
endpackage

// File: rtl/decode_strobe_qualifier_if.sv
// decode_strobe_qualifier_if: sample/handshake bus between the decode consumer and its user
interface decode_strobe_qualifier_if #(parameter int HIT_W = 8);
   logic             ce;
   logic [4:0]       i;
   logic             ack;
   logic             o_n;
   logic             valid;
   logic             busy;
   logic [HIT_W-1:0] hits;
   modport master (output ce, i, ack, input o_n, valid, busy, hits);
   modport slave (input ce, i, ack, output o_n, valid, busy, hits);
endinterface

// File: rtl/decode_strobe_qualifier_match_filter.sv
// decode_match_filter: decode compare plus run-length counter flagging the FILTER_LEN-th consecutive match
module decode_match_filter
   import decode_strobe_qualifier_pkg::*;
#(
   parameter int         FILTER_LEN = 3,
   parameter int         CNT_W      = 4,
   parameter logic [4:0] INV_MASK   = DEF_INV_MASK
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       arm,
   input  logic [4:0] i,
   output logic       match,
   output logic       qualified
);
   logic [CNT_W-1:0] cnt;
   assign match     = &(i ^ INV_MASK);
   assign qualified = match && (cnt == CNT_W'(FILTER_LEN - 1));
   // count matches while armed, park at FILTER_LEN-1 once qualified, clear otherwise; frozen when ce=0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         cnt <= '0;
      else if (ce)
         cnt <= (arm && match) ? (qualified ? cnt : cnt + 1'b1) : '0;
endmodule

// File: rtl/decode_strobe_qualifier.sv
// decode_strobe_qualifier: filtered strobe from an active-low decode with ack handshake; HIT_COUNT_EN adds a handshake counter
module decode_strobe_qualifier
   import decode_strobe_qualifier_pkg::*;
#(
   parameter int         FILTER_LEN = 3,
   parameter int         CNT_W      = 4,
   parameter logic [4:0] INV_MASK   = DEF_INV_MASK,
   parameter int         HIT_W      = 8
) (
   input logic                      clk,
   input logic                      rst_n,
   decode_strobe_qualifier_if.slave bus
);
   state_t state, state_nx;
   logic   match, qualified, valid, o_n;
   decode_match_filter #(.FILTER_LEN(FILTER_LEN), .CNT_W(CNT_W), .INV_MASK(INV_MASK)) u_filter (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (bus.ce),
      .arm      (state == IDLE || state == QUAL),
      .i        (bus.i),
      .match    (match),
      .qualified(qualified)
   );
   // next state: filtering and release wait need ce, but ack leaves HOLD even with ce low
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, QUAL: if (bus.ce) state_nx = match ? (qualified ? HOLD : QUAL) : IDLE;
         HOLD:       if (bus.ack) state_nx = WAIT_REL;
         WAIT_REL:   if (bus.ce && !match) state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end
   // state, registered strobe (tracks HOLD) and registered decode output
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         valid <= 1'b0;
         o_n   <= 1'b1;
      end else begin
         state <= state_nx;
         valid <= state_nx == HOLD;
         if (bus.ce) o_n <= ~match;
      end
   assign bus.valid = valid;
   assign bus.o_n   = o_n;
   assign bus.busy  = state != IDLE;
`ifdef HIT_COUNT_EN
   logic [HIT_W-1:0] hits;
   // count completed handshakes, sticking at all-ones
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         hits <= '0;
      else if (valid && bus.ack && !(&hits))
         hits <= hits + 1'b1;
   assign bus.hits = hits;
`else
   assign bus.hits = {HIT_W{1'b0}};
`endif
endmodule

// File: tb/tb_decode_strobe_qualifier.sv
// tb_decode_strobe_qualifier: directed vector table plus async-clear and saturation sequences
module tb_decode_strobe_qualifier;
`ifdef HIT_COUNT_EN
   localparam bit HC = 1'b1;
`else
   localparam bit HC = 1'b0;
`endif
   localparam logic [4:0] M = 5'b11000;
   localparam logic [4:0] N = 5'b11001;

   typedef struct {
      logic       rst_n, ce;
      logic [4:0] i;
      logic       ack, o_n, valid, busy;
      logic [7:0] hits;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   vec_t vecs[$];

   decode_strobe_qualifier_if #(.HIT_W(8)) bus ();
   decode_strobe_qualifier_if #(.HIT_W(2)) bus1 ();

   decode_strobe_qualifier #(.FILTER_LEN(3), .HIT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   decode_strobe_qualifier #(.FILTER_LEN(1), .HIT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, c, input logic [4:0] iv, input logic a, on, v, b, input logic [7:0] h);
      vec_t x;
      x.rst_n = r; x.ce = c; x.i = iv; x.ack = a; x.o_n = on; x.valid = v; x.busy = b; x.hits = h;
      vecs.push_back(x);
   endtask

   initial begin
      bus.ce = 1'b0; bus.i = '0; bus.ack = 1'b0;
      bus1.ce = 1'b0; bus1.i = '0; bus1.ack = 1'b0;
      // reset held with a matching decode
      add(0, 1, M, 0, 1, 0, 0, 0);
      add(0, 1, M, 0, 1, 0, 0, 0);
      // qualify, ack, sustained decode stays in WAIT_REL, release
      add(1, 1, M, 0, 0, 0, 1, 0);
      add(1, 1, M, 0, 0, 0, 1, 0);
      add(1, 1, M, 0, 0, 1, 1, 0);
      add(1, 1, M, 0, 0, 1, 1, 0);
      add(1, 1, M, 1, 0, 0, 1, 1);
      add(1, 1, M, 0, 0, 0, 1, 1);
      add(1, 1, N, 0, 1, 0, 0, 1);
      // glitch breaks the run; ack on the rising edge of valid is ignored
      add(1, 1, M, 0, 0, 0, 1, 1);
      add(1, 1, M, 0, 0, 0, 1, 1);
      add(1, 1, N, 0, 1, 0, 0, 1);
      add(1, 1, M, 0, 0, 0, 1, 1);
      add(1, 1, M, 0, 0, 0, 1, 1);
      add(1, 1, M, 1, 0, 1, 1, 1);
      add(1, 1, M, 1, 0, 0, 1, 2);
      add(1, 1, N, 0, 1, 0, 0, 2);
      // ce gap keeps the run and freezes o_n; ack with ce low still completes
      add(1, 1, M, 0, 0, 0, 1, 2);
      add(1, 1, M, 0, 0, 0, 1, 2);
      for (int k = 0; k < 5; k++) add(1, 0, N, 0, 0, 0, 1, 2);
      add(1, 1, M, 0, 0, 1, 1, 2);
      add(1, 0, M, 1, 0, 0, 1, 3);
      add(1, 0, N, 0, 0, 0, 1, 3);
      add(1, 1, N, 0, 1, 0, 0, 3);

      #1;
      foreach (vecs[k]) begin
         rst_n = vecs[k].rst_n; bus.ce = vecs[k].ce; bus.i = vecs[k].i; bus.ack = vecs[k].ack;
         edge_step();
         chk($sformatf("vec%0d o_n", k), 32'(bus.o_n), 32'(vecs[k].o_n));
         chk($sformatf("vec%0d valid", k), 32'(bus.valid), 32'(vecs[k].valid));
         chk($sformatf("vec%0d busy", k), 32'(bus.busy), 32'(vecs[k].busy));
         chk($sformatf("vec%0d hits", k), 32'(bus.hits), HC ? 32'(vecs[k].hits) : 32'd0);
      end

      // async clear while holding the strobe, then requalify from IDLE
      bus.ce = 1'b1; bus.i = M; bus.ack = 1'b0;
      for (int k = 0; k < 3; k++) edge_step();
      chk("pre-clear valid", 32'(bus.valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("clear valid", 32'(bus.valid), 32'd0);
      chk("clear busy", 32'(bus.busy), 32'd0);
      chk("clear o_n", 32'(bus.o_n), 32'd1);
      chk("clear hits", 32'(bus.hits), 32'd0);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         edge_step();
         chk($sformatf("requal%0d valid", k), 32'(bus.valid), k == 2 ? 32'd1 : 32'd0);
         chk($sformatf("requal%0d busy", k), 32'(bus.busy), 32'd1);
      end
      bus.ce = 1'b0;

      // FILTER_LEN=1: valid one edge after first match; HIT_W=2 saturates at 3
      bus1.ce = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         bus1.i = M; bus1.ack = 1'b0;
         edge_step();
         chk($sformatf("f1 hs%0d valid", k), 32'(bus1.valid), 32'd1);
         bus1.ack = 1'b1;
         edge_step();
         chk($sformatf("f1 hs%0d drop", k), 32'(bus1.valid), 32'd0);
         chk($sformatf("f1 hs%0d hits", k), 32'(bus1.hits), HC ? 32'(k > 3 ? 3 : k) : 32'd0);
         bus1.ack = 1'b0; bus1.i = N;
         edge_step();
         chk($sformatf("f1 hs%0d idle", k), 32'(bus1.busy), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
